// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - state, opcode, funct, ALU op and mux select codes for the multi-cycle control FSM
package mc_ctrl_pkg;

  localparam int STATE_W = 4;
  localparam int ALU_W   = 3;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REGB   = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

// File: rtl/mc_ctrl_if.sv
// rtl/mc_ctrl_if.sv - control FSM <-> datapath signal bundle; master = controller, slave = datapath
interface mc_ctrl_if #(
  parameter int STATE_W = 4,
  parameter int ALU_W   = 3
);
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic               zero;
  logic               mem_ready;
  logic               pc_ce;
  logic               ir_ce;
  logic               mdr_ce;
  logic               reg_we;
  logic               mem_rd;
  logic               mem_wr;
  logic               iord;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [ALU_W-1:0]   alu_ctrl;
  logic [1:0]         pc_src;
  logic               reg_dst;
  logic               mem_to_reg;
  logic               illegal;
  logic [STATE_W-1:0] state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_ce, ir_ce, mdr_ce, reg_we, mem_rd, mem_wr, iord, alu_src_a, alu_src_b,
           alu_ctrl, pc_src, reg_dst, mem_to_reg, illegal, state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_ce, ir_ce, mdr_ce, reg_we, mem_rd, mem_wr, iord, alu_src_a, alu_src_b,
           alu_ctrl, pc_src, reg_dst, mem_to_reg, illegal, state
  );
endinterface

// File: rtl/mc_alu_dec.sv
// rtl/mc_alu_dec.sv - R-type funct to ALU operation decode, flags unsupported funct codes
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [2:0] alu_ctrl_o,
  output logic       funct_ok_o
);

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    funct_ok_o = 1'b1;
    case (funct_i)
      FN_ADD:  alu_ctrl_o = ALU_ADD;
      FN_SUB:  alu_ctrl_o = ALU_SUB;
      FN_AND:  alu_ctrl_o = ALU_AND;
      FN_OR:   alu_ctrl_o = ALU_OR;
      FN_SLT:  alu_ctrl_o = ALU_SLT;
      default: funct_ok_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle CPU main control FSM (R-type, lw, sw, beq, j, addi)
// MC_CTRL_MEM_WAIT_EN: memory states stall on mem_ready; otherwise each lasts one cycle.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int STATE_W = 4,
  parameter int ALU_W   = 3
) (
  input  logic       clk,
  input  logic       rst,
  mc_ctrl_if.master  bus
);

  state_t     state_q, state_d;
  logic       mem_go;
  logic [2:0] dec_alu_ctrl;
  logic       dec_funct_ok;

  logic       pc_ce, ir_ce, mdr_ce, reg_we, mem_rd, mem_wr;
  logic       iord, alu_src_a, reg_dst, mem_to_reg, illegal;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_ctrl;

`ifdef MC_CTRL_MEM_WAIT_EN
  assign mem_go = bus.mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = bus.mem_ready;
  assign mem_go = 1'b1;
`endif

  mc_alu_dec u_alu_dec (
    .funct_i    (bus.funct),
    .alu_ctrl_o (dec_alu_ctrl),
    .funct_ok_o (dec_funct_ok)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pc_ce      = 1'b0;
    ir_ce      = 1'b0;
    mdr_ce     = 1'b0;
    reg_we     = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    iord       = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REGB;
    alu_ctrl   = ALU_AND;
    pc_src     = PCSRC_ALU;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_rd    = 1'b1;
        ir_ce     = mem_go;
        pc_ce     = mem_go;
        alu_src_b = SRCB_FOUR;
        alu_ctrl  = ALU_ADD;
        pc_src    = PCSRC_ALU;
        if (mem_go) state_d = S_DECODE;
      end
      S_DECODE: begin
        // ALUOut captures the branch target here so BRANCH can use the ALU for the compare
        alu_src_b = SRCB_IMM_SH;
        alu_ctrl  = ALU_ADD;
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_RTYPE: begin
            state_d = dec_funct_ok ? S_EXEC : S_FETCH;
            illegal = !dec_funct_ok;
          end
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_ctrl  = ALU_ADD;
        state_d   = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord   = 1'b1;
        mem_rd = 1'b1;
        mdr_ce = mem_go;
        if (mem_go) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        iord   = 1'b1;
        mem_wr = 1'b1;
        if (mem_go) state_d = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_ctrl  = dec_alu_ctrl;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_we  = 1'b1;
        reg_dst = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctrl  = ALU_SUB;
        pc_src    = PCSRC_ALUOUT;
        pc_ce     = bus.zero;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_src  = PCSRC_JUMP;
        pc_ce   = 1'b1;
        state_d = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_ctrl  = ALU_ADD;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_we  = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset must silence the FETCH decode immediately, not one edge later
    if (!rst) begin
      pc_ce      = 1'b0;
      ir_ce      = 1'b0;
      mdr_ce     = 1'b0;
      reg_we     = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      iord       = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_REGB;
      alu_ctrl   = ALU_AND;
      pc_src     = PCSRC_ALU;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      illegal    = 1'b0;
    end
  end

  assign bus.pc_ce      = pc_ce;
  assign bus.ir_ce      = ir_ce;
  assign bus.mdr_ce     = mdr_ce;
  assign bus.reg_we     = reg_we;
  assign bus.mem_rd     = mem_rd;
  assign bus.mem_wr     = mem_wr;
  assign bus.iord       = iord;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.alu_ctrl   = ALU_W'(alu_ctrl);
  assign bus.pc_src     = pc_src;
  assign bus.reg_dst    = reg_dst;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.illegal    = illegal;
  assign bus.state      = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - directed self-checking bench for mc_ctrl; enables packed as {pc,ir,mdr,we,rd,wr}
module tb_mc_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mc_ctrl_if bus ();

  mc_ctrl dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] en();
    return {26'd0, bus.pc_ce, bus.ir_ce, bus.mdr_ce, bus.reg_we, bus.mem_rd, bus.mem_wr};
  endfunction

  task automatic step(input string tag, input logic [31:0] st, input logic [31:0] e);
    check({tag, "_state"}, 32'(bus.state), st);
    check({tag, "_en"}, en(), e);
    @(negedge clk);
  endtask

  logic [5:0] fn_tab [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  logic [2:0] alu_tab[5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

  initial begin
    rst_n         = 1'b0;
    bus.opcode    = 6'h00;
    bus.funct     = 6'h00;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;

    repeat (4) begin
      @(negedge clk);
      bus.opcode    = 6'($urandom);
      bus.funct     = 6'($urandom);
      bus.zero      = 1'($urandom);
      bus.mem_ready = 1'($urandom);
      #1;
      check("rst_en", en(), 32'h0);
      check("rst_illegal", 32'(bus.illegal), 32'h0);
      check("rst_state", 32'(bus.state), 32'h0);
      check("rst_sel", {23'd0, bus.iord, bus.alu_src_a, bus.alu_src_b, bus.pc_src,
                        bus.reg_dst, bus.mem_to_reg}, 32'h0);
    end

    @(negedge clk);
    bus.mem_ready = 1'b1;
    bus.zero      = 1'b0;
    bus.opcode    = 6'h23;
    rst_n         = 1'b1;
    #1;
    check("fetch_srcb", 32'(bus.alu_src_b), 32'd1);
    check("fetch_alu", 32'(bus.alu_ctrl), 32'b010);

    // lw: 0,1,2,3,4,0
    step("lw_fetch", 0, 32'b110010);
    check("lw_dec_srcb", 32'(bus.alu_src_b), 32'd3);
    step("lw_dec", 1, 32'b000000);
    check("lw_adr_srcb", 32'(bus.alu_src_b), 32'd2);
    step("lw_adr", 2, 32'b000000);
    check("lw_rd_iord", 32'(bus.iord), 32'd1);
    step("lw_rd", 3, 32'b001010);
    check("lw_wb_m2r", 32'(bus.mem_to_reg), 32'd1);
    check("lw_wb_dst", 32'(bus.reg_dst), 32'd0);
    step("lw_wb", 4, 32'b000100);

    // beq taken then not taken
    for (int z = 1; z >= 0; z--) begin
      bus.opcode = 6'h04;
      bus.zero   = 1'(z);
      step("beq_fetch", 0, 32'b110010);
      step("beq_dec", 1, 32'b000000);
      check("beq_pcsrc", 32'(bus.pc_src), 32'd1);
      check("beq_alu", 32'(bus.alu_ctrl), 32'b110);
      step("beq_br", 8, (z == 1) ? 32'b100000 : 32'b000000);
    end

    // j
    bus.opcode = 6'h02;
    step("j_fetch", 0, 32'b110010);
    step("j_dec", 1, 32'b000000);
    check("j_pcsrc", 32'(bus.pc_src), 32'd2);
    step("j_jump", 9, 32'b100000);

    // R-type, every supported funct
    for (int i = 0; i < 5; i++) begin
      bus.opcode = 6'h00;
      bus.funct  = fn_tab[i];
      step("r_fetch", 0, 32'b110010);
      check("r_dec_illegal", 32'(bus.illegal), 32'd0);
      step("r_dec", 1, 32'b000000);
      check("r_exec_alu", 32'(bus.alu_ctrl), 32'(alu_tab[i]));
      check("r_exec_srca", 32'(bus.alu_src_a), 32'd1);
      step("r_exec", 6, 32'b000000);
      check("r_wb_dst", 32'(bus.reg_dst), 32'd1);
      step("r_wb", 7, 32'b000100);
    end

    // unsupported funct, then unsupported opcode
    bus.funct = 6'h3F;
    step("badfn_fetch", 0, 32'b110010);
    check("badfn_illegal", 32'(bus.illegal), 32'd1);
    step("badfn_dec", 1, 32'b000000);
    check("badfn_after", 32'(bus.illegal), 32'd0);
    bus.opcode = 6'h3F;
    step("badop_fetch", 0, 32'b110010);
    check("badop_illegal", 32'(bus.illegal), 32'd1);
    step("badop_dec", 1, 32'b000000);
    check("badop_after", 32'(bus.illegal), 32'd0);

    // addi
    bus.opcode = 6'h08;
    step("addi_fetch", 0, 32'b110010);
    step("addi_dec", 1, 32'b000000);
    check("addi_ex_srcb", 32'(bus.alu_src_b), 32'd2);
    step("addi_ex", 10, 32'b000000);
    check("addi_wb_dst", 32'(bus.reg_dst), 32'd0);
    check("addi_wb_m2r", 32'(bus.mem_to_reg), 32'd0);
    step("addi_wb", 11, 32'b000100);

`ifdef MC_CTRL_MEM_WAIT_EN
    bus.opcode    = 6'h23;
    bus.mem_ready = 1'b0;
    repeat (3) step("wait_fetch", 0, 32'b000010);
    bus.mem_ready = 1'b1;
    step("wait_fetch_go", 0, 32'b110010);
    step("wait_dec", 1, 32'b000000);
    step("wait_adr", 2, 32'b000000);
    bus.mem_ready = 1'b0;
    step("wait_rd", 3, 32'b000010);
    bus.mem_ready = 1'b1;
    step("wait_rd_go", 3, 32'b001010);
    step("wait_wb", 4, 32'b000100);
`endif

    // sw with reset pulsed in MEMWR
    bus.opcode = 6'h2B;
    step("sw_fetch", 0, 32'b110010);
    step("sw_dec", 1, 32'b000000);
    step("sw_adr", 2, 32'b000000);
    check("sw_wr_state", 32'(bus.state), 32'd5);
    check("sw_wr_en", en(), 32'b000001);
    #2 rst_n = 1'b0;
    #1;
    check("sw_rst_en", en(), 32'h0);
    check("sw_rst_state", 32'(bus.state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    step("sw_after_rst", 0, 32'b110010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
